// File: rtl/button_pkg.sv
// button_pkg: shared hold-FSM state encoding, pulse bundle and counter sizing helper
package button_pkg;
   typedef enum logic [1:0] {
      REL  = 2'd0,
      DOWN = 2'd1,
      LONG = 2'd2
   } hold_state_e;
   typedef struct packed {
      logic prs;
      logic rls;
      logic lng;
      logic rpt;
   } evt_t;
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button lane -- 2-flop sync, debounce, hold FSM with long/repeat events
//   clk, rst_n (sync, active-low); button raw pin in;
//   pressed debounced level; press/release/long/repeat_pulse registered one-cycle events
module btn_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000,
   parameter int ACTIVE_HIGH     = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);
   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int HW = cnt_width(LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES);
   localparam logic [DW-1:0] DEB_TC  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_TC = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] REP_TC  = HW'(REPEAT_CYCLES - 1);

   logic s1_q, s1_d, s2_q;
   logic deb_q, deb_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   hold_state_e state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   evt_t evt_q, evt_d;

   // Inversion ahead of the synchronizer so everything downstream sees 1 = pressed.
   always_comb begin
      s1_d   = (ACTIVE_HIGH != 0) ? button : ~button;
      deb_d  = (s2_q != deb_q && dcnt_q == DEB_TC) ? ~deb_q : deb_q;
      dcnt_d = (s2_q == deb_q || dcnt_q == DEB_TC) ? '0 : dcnt_q + 1'b1;
   end

   // deb_q is registered once more into the FSM, so the visible level and the
   // press/release pulse appear together, DEBOUNCE_CYCLES+2 after the sampling edge.
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q + 1'b1;
      evt_d   = '0;
      case (state_q)
         REL: begin
            hcnt_d = '0;
            if (deb_q) begin
               evt_d.prs = 1'b1;
               state_d   = DOWN;
            end
         end
         DOWN, LONG: begin
            if (!deb_q) begin
               // Release takes priority over a coincident long/repeat terminal count.
               evt_d.rls = 1'b1;
               hcnt_d    = '0;
               state_d   = REL;
            end else if (hcnt_q == ((state_q == DOWN) ? LONG_TC : REP_TC)) begin
               evt_d.lng = (state_q == DOWN);
               evt_d.rpt = (state_q == LONG);
               hcnt_d    = '0;
               state_d   = LONG;
            end
         end
         default: begin
            hcnt_d  = '0;
            state_d = REL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         deb_q   <= 1'b0;
         dcnt_q  <= '0;
         state_q <= REL;
         hcnt_q  <= '0;
         evt_q   <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s1_q;
         deb_q   <= deb_d;
         dcnt_q  <= dcnt_d;
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         evt_q   <= evt_d;
      end
   end

   assign pressed       = (state_q != REL);
   assign press_pulse   = evt_q.prs;
   assign release_pulse = evt_q.rls;
   assign long_pulse    = evt_q.lng;
   assign repeat_pulse  = evt_q.rpt;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_BTN independent debounced buttons with press/release/long/repeat events
//   clk, rst_n (sync, active-low); button[N_BTN] raw pins;
//   pressed[N_BTN] levels; press/release/long/repeat_pulse[N_BTN] one-cycle events
module button_conditioner
   import button_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000,
   parameter int ACTIVE_HIGH     = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] button,
   output logic [N_BTN-1:0] pressed,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse,
   output logic [N_BTN-1:0] long_pulse,
   output logic [N_BTN-1:0] repeat_pulse
);
   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .LONG_CYCLES    (LONG_CYCLES),
         .REPEAT_CYCLES  (REPEAT_CYCLES),
         .ACTIVE_HIGH    (ACTIVE_HIGH)
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .button       (button[i]),
         .pressed      (pressed[i]),
         .press_pulse  (press_pulse[i]),
         .release_pulse(release_pulse[i]),
         .long_pulse   (long_pulse[i]),
         .repeat_pulse (repeat_pulse[i])
      );
   end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed timing pins plus randomized run against a run-length/hold-time model
module tb_button_conditioner;
   localparam int N = 2, DEB = 4, LNG = 10, REP = 3;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0] button = '0;
   logic [N-1:0] pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;
   int checks = 0, errors = 0, npress0 = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP), .ACTIVE_HIGH(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .button(button), .pressed(pressed),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: a raw level is accepted after DEB consecutive disagreeing samples seen
   // through a 2-sample delay; outputs follow one cycle later. Long/repeat events
   // are derived from the held time h since press: h == LNG, then every REP.
   logic [N-1:0] sy0, sy1, lvl, mp, x_pp, x_rl, x_lg, x_rp;
   int run [N];
   int hold [N];
   initial forever begin
      logic v, lp, held;
      @(posedge clk);
      if (!rst_n) begin
         sy0 = '0; sy1 = '0; lvl = '0; mp = '0;
         x_pp = '0; x_rl = '0; x_lg = '0; x_rp = '0;
         for (int c = 0; c < N; c++) begin
            run[c] = 0;
            hold[c] = 0;
         end
      end else begin
         for (int c = 0; c < N; c++) begin
            v  = sy1[c];
            lp = lvl[c];
            sy1[c] = sy0[c];
            sy0[c] = button[c];
            if (v == lvl[c]) run[c] = 0;
            else begin
               run[c]++;
               if (run[c] == DEB) begin
                  lvl[c] = ~lvl[c];
                  run[c] = 0;
               end
            end
            held    = lp & mp[c];
            x_pp[c] = lp & ~mp[c];
            x_rl[c] = ~lp & mp[c];
            if (x_pp[c]) hold[c] = 0;
            else if (held) hold[c]++;
            x_lg[c] = held && hold[c] == LNG;
            x_rp[c] = held && hold[c] > LNG && (hold[c] - LNG) % REP == 0;
            mp[c]   = lp;
         end
      end
      @(negedge clk);
      chk("model", 32'({pressed, press_pulse, release_pulse, long_pulse, repeat_pulse}),
          32'({mp, x_pp, x_rl, x_lg, x_rp}));
      if (press_pulse[0]) npress0++;
   end

   initial begin
      int n0;
      int dur [N];
      tick(3);
      chk("reset_outputs", 32'({pressed, press_pulse, release_pulse, long_pulse, repeat_pulse}), 32'd0);
      rst_n = 1'b1;
      tick(2);
      // single press, hold through long press and repeats, release on a repeat terminal count
      button[0] = 1'b1;
      tick(6);
      chk("pressed_before_latency", 32'(pressed[0]), 32'd0);
      tick(1);
      chk("pressed_at_latency", 32'(pressed[0]), 32'd1);
      chk("press_pulse_at_latency", 32'(press_pulse), 32'd1);
      tick(1);
      chk("press_pulse_one_cycle", 32'(press_pulse), 32'd0);
      tick(8);
      chk("long_not_early", 32'(long_pulse), 32'd0);
      tick(1);
      chk("long_at_10", 32'(long_pulse), 32'd1);
      tick(2);
      chk("repeat_not_early", 32'(repeat_pulse), 32'd0);
      tick(1);
      chk("repeat_first", 32'(repeat_pulse), 32'd1);
      tick(3);
      chk("repeat_second", 32'(repeat_pulse), 32'd1);
      tick(2);
      button[0] = 1'b0;
      tick(4);
      chk("repeat_third", 32'(repeat_pulse), 32'd1);
      tick(3);
      chk("release_on_tc", 32'(release_pulse), 32'd1);
      chk("no_repeat_on_release", 32'(repeat_pulse), 32'd0);
      chk("pressed_low_on_release", 32'(pressed), 32'd0);
      tick(10);
      // bouncing contact: only the final stable run is accepted
      n0 = npress0;
      button[0] = 1'b1; tick(2);
      button[0] = 1'b0; tick(2);
      button[0] = 1'b1; tick(2);
      button[0] = 1'b0; tick(2);
      button[0] = 1'b1;
      tick(6);
      chk("bounce_no_early_press", 32'(press_pulse), 32'd0);
      tick(1);
      chk("bounce_press", 32'(press_pulse), 32'd1);
      tick(1);
      chk("bounce_single_press", 32'(npress0 - n0), 32'd1);
      button[0] = 1'b0;
      tick(12);
      // simultaneous presses, then reset mid-hold and re-acceptance
      button = 2'b11;
      tick(7);
      chk("dual_press", 32'(press_pulse), 32'd3);
      tick(5);
      rst_n = 1'b0;
      tick(1);
      chk("reset_midhold_outputs", 32'({pressed, press_pulse, release_pulse, long_pulse, repeat_pulse}), 32'd0);
      tick(1);
      chk("reset_no_release", 32'(release_pulse), 32'd0);
      rst_n = 1'b1;
      tick(6);
      chk("reaccept_not_early", 32'(pressed), 32'd0);
      tick(1);
      chk("reaccept_press", 32'(press_pulse), 32'd3);
      // randomized run: mixes short bounces with holds long enough for repeats
      button = '0;
      for (int c = 0; c < N; c++) dur[c] = 0;
      for (int k = 0; k < 4000; k++) begin
         for (int c = 0; c < N; c++) begin
            if (dur[c] == 0) begin
               button[c] = 1'($urandom_range(0, 1));
               dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 45);
            end
            dur[c]--;
         end
         rst_n = ($urandom_range(0, 599) != 0);
         tick(1);
      end
      rst_n = 1'b1;
      button = '0;
      tick(20);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 65536, consecutive stable cycles required to accept a level change (min 2).
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000, debounced-held cycles before a long-press event (min 2).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 10000000, period of auto-repeat pulses after a long press (min 2).
REQ-005 SHALL have parameter ACTIVE_HIGH, default 1; 1 = raw button reads 1 when pressed, 0 = inverted.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port button  input  N_BTN  raw asynchronous button pins.
REQ-009 SHALL have port pressed  output  N_BTN  debounced level, 1 = held.
REQ-010 SHALL have port press_pulse  output  N_BTN  one-cycle pulse on accepted press.
REQ-011 SHALL have port release_pulse  output  N_BTN  one-cycle pulse on accepted release.
REQ-012 SHALL have port long_pulse  output  N_BTN  one-cycle pulse when hold reaches LONG_CYCLES.
REQ-013 SHALL have port repeat_pulse  output  N_BTN  one-cycle pulse every REPEAT_CYCLES while held after long press.

Function
REQ-014 SHALL pass each button bit through a 2-flop synchronizer, applying ACTIVE_HIGH inversion before the first flop.
REQ-015 SHALL, per channel, clear the debounce counter whenever synchronized level equals pressed, else increment it.
REQ-016 SHALL toggle pressed and clear the counter on the cycle the counter equals DEBOUNCE_CYCLES-1 while level still differs; any glitch back to pressed level restarts the count.
REQ-017 SHALL therefore assert pressed exactly DEBOUNCE_CYCLES+2 cycles after the first clock edge sampling a stable new raw level.
REQ-018 SHALL run per channel a hold FSM with states REL, DOWN, LONG.
REQ-019 SHALL in REL, on pressed rising: pulse press_pulse, clear hold counter, go DOWN.
REQ-020 SHALL in DOWN, count held cycles; on count LONG_CYCLES-1: pulse long_pulse, clear counter, go LONG.
REQ-021 SHALL in LONG, count; on count REPEAT_CYCLES-1: pulse repeat_pulse, clear counter, stay LONG.
REQ-022 SHALL from DOWN or LONG, on pressed falling: pulse release_pulse, go REL; release wins over a coincident long/repeat terminal count (no long/repeat pulse that cycle).
REQ-023 SHALL keep hold counter width sufficient for max(LONG_CYCLES, REPEAT_CYCLES) without wrap; debounce counter width sufficient for DEBOUNCE_CYCLES.
REQ-024 SHALL register all pulse outputs; at most one of press/release/long/repeat per channel per cycle.
REQ-025 SHALL keep channels fully independent; simultaneous events on different channels all reported same cycle.

Reset
REQ-026 SHALL on rst_n low at a clock edge set synchronizers to released level, all counters to 0, FSMs to REL, all outputs to 0.
REQ-027 SHALL, when reset is applied mid-hold, produce no release_pulse; after reset a still-held button is re-accepted as a new press after DEBOUNCE_CYCLES+2 cycles.

Structure
REQ-028 SHALL place hold-FSM state encoding (REL, DOWN, LONG) in shared package button_pkg.
REQ-029 SHALL implement one channel as sub-module btn_channel, instantiated N_BTN times via generate.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, N_BTN=2)
REQ-030 SHALL: button[0] 0->1 held -> pressed[0] and press_pulse[0] high 6 cycles after first sampling edge, press_pulse exactly 1 cycle.
REQ-031 SHALL: button[0] bounce 1,0,1,0 each 2 cycles then stable 1 -> single press_pulse, 6 cycles after stable start.
REQ-032 SHALL: hold 30 cycles past press -> long_pulse 10 cycles after press_pulse, then repeat_pulse every 3 cycles.
REQ-033 SHALL: release so pressed falls on the repeat terminal-count cycle -> release_pulse only, no repeat_pulse.
REQ-034 SHALL: both buttons pressed same cycle -> press_pulse = 2'b11 same cycle; rst_n low mid-hold -> all outputs 0, no release_pulse.
